double_buffer_ctrl: RTL and testbench
=====================================

# double_buffer_ctrl

Sequencer for the `double_buffer` block. It turns a valid/ready producer stream into bank writes and the read bank into a valid/ready consumer stream. It issues `switch_banks` exactly when the write bank holds a full block and the read bank is drained or empty. It sits between the upstream producer, the `double_buffer` instance and the downstream consumer.

## Interface
- `DATA_WIDTH`, 64, word width.
- `BANK_ADDR_WIDTH`, 5, bank address width.
- `BLOCK_SIZE`, 32, words per block. Legal range 1..2^BANK_ADDR_WIDTH.
- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset. It is shared with the `double_buffer` instance.
- `in_valid` in 1, `in_ready` out 1, `in_data` in DATA_WIDTH: producer stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out DATA_WIDTH: consumer stream.
- `db_wen` out 1, `db_wadr` out BANK_ADDR_WIDTH, `db_wdata` out DATA_WIDTH: `double_buffer` write port.
- `db_ren` out 1, `db_radr` out BANK_ADDR_WIDTH, `db_rdata` in DATA_WIDTH: `double_buffer` read port.
  - Synchronous read: data is valid in the cycle after `db_ren`.
- `db_switch_banks` out 1: one-cycle pulse that swaps the banks.
- `bank_sel` out 1: mirror of the `double_buffer` read-bank index.

## Operation
- **State**
  - `wr_cnt`, `rd_cnt`: width BANK_ADDR_WIDTH+1, range 0..BLOCK_SIZE.
  - `rd_avail`: the read bank holds a block.
  - `inflight`: a read was issued last cycle.
  - Output FIFO: 2 entries.
  - `bank_sel`.
- **Write side**
  - `in_ready = (wr_cnt != BLOCK_SIZE)`.
  - On `in_valid && in_ready`: `db_wen=1`, `db_wadr=wr_cnt[BANK_ADDR_WIDTH-1:0]`, `db_wdata=in_data`, then `wr_cnt++`.
- **Read side**
  - Issue condition: `rd_avail && rd_cnt != BLOCK_SIZE && (fifo_count + inflight − pop) < 2`, where `pop = out_valid && out_ready`.
  - On issue: `db_ren=1`, `db_radr=rd_cnt[BANK_ADDR_WIDTH-1:0]`, then `rd_cnt++`.
  - Next cycle `db_rdata` is pushed into the FIFO.
  - `out_valid` = FIFO not empty; `out_data` = FIFO head.
- **Bank switch**
  - Switch condition: `wr_cnt==BLOCK_SIZE && (!rd_avail || (rd_cnt==BLOCK_SIZE && !inflight))`.
  - In that cycle `db_switch_banks=1`.
  - At the edge: `wr_cnt<=0`, `rd_cnt<=0`, `rd_avail<=1`, `bank_sel<=~bank_sel`.
- **Read-bank status** (enum): `RB_EMPTY` (`!rd_avail`) → `RB_DRAINING` on switch. It stays `RB_DRAINING` across later switches, because each switch refills it.
- **Simultaneous events**
  - A write and a read in the same cycle are independent.
  - In the switch cycle there is never a write (`in_ready=0`) and never a read issue (`rd_cnt==BLOCK_SIZE` or `!rd_avail`).
  - A FIFO push and pop in the same cycle keep the count unchanged.
- **Reset**, asynchronous, at any point including mid-block:
  - All counters 0, `rd_avail=0`, `inflight=0`, FIFO empty, `bank_sel=0`.
  - Partial blocks are discarded.
- **Reset output values**
  - 1: `in_ready`.
  - 0: `out_valid`, `db_wen`, `db_ren`, `db_switch_banks`, `bank_sel`.
  - Addresses 0; `out_data` don't-care.

## Timing
- Write: zero latency, one word per cycle while `in_ready`.
- Read latency: `db_ren` in cycle t → data in FIFO at the end of t+1 → `out_valid` in t+2.
- Sustained read throughput: 1 word/cycle with `out_ready` held high.
- Switch bubble: `in_ready` is low for exactly 1 cycle (the switch cycle) when the read bank is already drained.
- With `out_ready` held low, the read side stalls after 2 words. The write side then stalls once `wr_cnt==BLOCK_SIZE`. No data is lost or reordered.
- `db_switch_banks` is never high on consecutive cycles.

## Structure
- Package `double_buffer_pkg` holds:
  - `OUT_FIFO_DEPTH=2`.
  - The read-bank status enum `{RB_EMPTY, RB_DRAINING}`.
  - The counter width function `$clog2(BLOCK_SIZE+1)` helper.
- One sub-module: `db_out_fifo`, a 2-entry FIFO with push/pop/count/head. It is parameterised on DATA_WIDTH.
- Top-level tests instantiate `double_buffer_ctrl` and `double_buffer` together.

## Test plan
Bench parameters: BLOCK_SIZE=4, BANK_ADDR_WIDTH=2.
- **First fill:** stream 0..3 with `out_ready=1`.
  - `db_wadr` 0,1,2,3.
  - `db_switch_banks` pulses the cycle after the last write.
  - `out_data` 0,1,2,3 starting 3 cycles after the switch.
- **Continuous stream:** 0..15 with `in_valid` and `out_ready` held high.
  - Output is 0..15 in order.
  - Exactly 4 switches.
  - `bank_sel` toggles 4 times and ends at 0.
- **Back-pressure:** `out_ready=0` while writing 0..7.
  - `in_ready` falls after word 7.
  - `out_valid=1` with `out_data=0` held.
  - Releasing `out_ready` yields 0..7.
- **Random gaps:** random `in_valid`/`out_ready` at 50% over 64 words.
  - Scoreboard matches in order.
  - `db_switch_banks` never overlaps `db_wen` or `db_ren`.
- **Reset mid-block:** assert `rst_n=0` after 2 words of the second block.
  - All outputs reach their reset values immediately.
  - A new stream 100..103 outputs 100..103 only.

Source files
------------

// File: rtl/double_buffer_pkg.sv
// Shared constants and types for the double_buffer sequencer and its output FIFO.
package double_buffer_pkg;

   localparam int OUT_FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W     = $clog2(OUT_FIFO_DEPTH + 1);
   localparam int FIFO_PTR_W     = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;

   typedef enum logic {
      RB_EMPTY    = 1'b0,
      RB_DRAINING = 1'b1
   } rb_status_e;

   function automatic int cnt_width(input int block_size);
      return $clog2(block_size + 1);
   endfunction

endpackage

// File: rtl/db_out_fifo.sv
// Small output FIFO that absorbs the one-cycle read latency of the bank memory.
module db_out_fifo
   import double_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [FIFO_CNT_W-1:0] count,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  not_empty
);

   logic [DATA_WIDTH-1:0] mem_q [OUT_FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [OUT_FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_CNT_W-1:0] count_q, count_d;

   localparam logic [FIFO_PTR_W-1:0] LAST_PTR = FIFO_PTR_W'(OUT_FIFO_DEPTH - 1);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count     = count_q;
   assign head      = mem_q[rd_ptr_q];
   assign not_empty = (count_q != '0);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (count_q == FIFO_CNT_W'(OUT_FIFO_DEPTH))));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && (count_q == '0)));

endmodule

// File: rtl/double_buffer_ctrl.sv
// Sequencer for double_buffer: producer stream -> write bank, read bank -> consumer
// stream, with a bank swap once the write bank is full and the read bank is done.
module double_buffer_ctrl
   import double_buffer_pkg::*;
#(
   parameter int DATA_WIDTH      = 64,
   parameter int BANK_ADDR_WIDTH = 5,
   parameter int BLOCK_SIZE      = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH-1:0]      in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic                       db_wen,
   output logic [BANK_ADDR_WIDTH-1:0] db_wadr,
   output logic [DATA_WIDTH-1:0]      db_wdata,
   output logic                       db_ren,
   output logic [BANK_ADDR_WIDTH-1:0] db_radr,
   input  logic [DATA_WIDTH-1:0]      db_rdata,
   output logic                       db_switch_banks,
   output logic                       bank_sel
);

   localparam int CNT_W = BANK_ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]      BLOCK_CNT = CNT_W'(BLOCK_SIZE);
   localparam logic [FIFO_CNT_W:0]   OCC_MAX   = (FIFO_CNT_W + 1)'(OUT_FIFO_DEPTH);

   rb_status_e            rb_status_q, rb_status_d;
   logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
   logic                  inflight_q, inflight_d;
   logic                  bank_sel_q, bank_sel_d;

   logic                  rd_avail;
   logic                  wr_fire;
   logic                  rd_issue;
   logic                  do_switch;
   logic                  pop;
   logic [FIFO_CNT_W-1:0] fifo_count;
   logic [FIFO_CNT_W:0]   fifo_occ;
   logic                  fifo_not_empty;
   logic [DATA_WIDTH-1:0] fifo_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rb_status_q <= RB_EMPTY;
      end else begin
         rb_status_q <= rb_status_d;
      end
   end

   // Each swap refills the read bank, so DRAINING is never left until reset.
   always_comb begin
      rb_status_d = rb_status_q;
      case (rb_status_q)
         RB_EMPTY:    if (do_switch) rb_status_d = RB_DRAINING;
         RB_DRAINING: rb_status_d = RB_DRAINING;
         default:     rb_status_d = RB_EMPTY;
      endcase
   end

   always_comb begin
      rd_avail = (rb_status_q == RB_DRAINING);
      in_ready = (wr_cnt_q != BLOCK_CNT);
      wr_fire  = in_valid && in_ready;
      pop      = fifo_not_empty && out_ready;

      // Pop only happens with a non-empty FIFO, so this never underflows.
      fifo_occ = {1'b0, fifo_count}
               + {{FIFO_CNT_W{1'b0}}, inflight_q}
               - {{FIFO_CNT_W{1'b0}}, pop};

      rd_issue  = rd_avail && (rd_cnt_q != BLOCK_CNT) && (fifo_occ < OCC_MAX);
      do_switch = (wr_cnt_q == BLOCK_CNT)
               && (!rd_avail || ((rd_cnt_q == BLOCK_CNT) && !inflight_q));

      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      inflight_d = rd_issue;
      bank_sel_d = bank_sel_q;

      if (do_switch) begin
         wr_cnt_d   = '0;
         rd_cnt_d   = '0;
         bank_sel_d = ~bank_sel_q;
      end else begin
         if (wr_fire)  wr_cnt_d = wr_cnt_q + 1'b1;
         if (rd_issue) rd_cnt_d = rd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         inflight_q <= 1'b0;
         bank_sel_q <= 1'b0;
      end else begin
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         inflight_q <= inflight_d;
         bank_sel_q <= bank_sel_d;
      end
   end

   db_out_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (db_rdata),
      .pop       (pop),
      .count     (fifo_count),
      .head      (fifo_head),
      .not_empty (fifo_not_empty)
   );

   assign db_wen          = wr_fire;
   assign db_wadr         = wr_cnt_q[BANK_ADDR_WIDTH-1:0];
   assign db_wdata        = in_data;
   assign db_ren          = rd_issue;
   assign db_radr         = rd_cnt_q[BANK_ADDR_WIDTH-1:0];
   assign db_switch_banks = do_switch;
   assign bank_sel        = bank_sel_q;
   assign out_valid       = fifo_not_empty;
   assign out_data        = fifo_head;

   a_switch_single: assert property (@(posedge clk) disable iff (!rst_n)
      db_switch_banks |=> !db_switch_banks);
   a_switch_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      db_switch_banks |-> !(db_wen || db_ren));

endmodule

// File: tb/tb_double_buffer_ctrl.sv
// Directed bench for double_buffer_ctrl with a behavioural two-bank memory attached.
module tb_double_buffer_ctrl;

   localparam int DW = 64;
   localparam int AW = 2;
   localparam int BS = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          db_wen;
   logic [AW-1:0] db_wadr;
   logic [DW-1:0] db_wdata;
   logic          db_ren;
   logic [AW-1:0] db_radr;
   logic [DW-1:0] db_rdata;
   logic          db_switch_banks;
   logic          bank_sel;

   always #5 clk = ~clk;

   double_buffer_ctrl #(
      .DATA_WIDTH      (DW),
      .BANK_ADDR_WIDTH (AW),
      .BLOCK_SIZE      (BS)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .db_wen          (db_wen),
      .db_wadr         (db_wadr),
      .db_wdata        (db_wdata),
      .db_ren          (db_ren),
      .db_radr         (db_radr),
      .db_rdata        (db_rdata),
      .db_switch_banks (db_switch_banks),
      .bank_sel        (bank_sel)
   );

   // Two-bank memory: writes go to the bank not being read; read data is registered.
   logic [DW-1:0] bank_mem [2][BS];
   logic          model_rd_bank;
   logic [DW-1:0] model_rdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_rd_bank <= 1'b0;
      else if (db_switch_banks) model_rd_bank <= !model_rd_bank;
   end

   always @(posedge clk) begin
      if (db_wen) bank_mem[!model_rd_bank][db_wadr] <= db_wdata;
      if (db_ren) model_rdata <= bank_mem[model_rd_bank][db_radr];
   end

   assign db_rdata = model_rdata;

   int total = 0;
   int bad   = 0;

   int            cyc;
   int            acc_cnt;
   logic [DW-1:0] out_q [$];
   int            n_switch, n_overlap, n_consec, n_toggle;
   int            first_switch_cyc, first_out_cyc, last_out_cyc;
   logic          prev_sw, prev_bank_sel;

   task automatic clear_log();
      cyc = 0; acc_cnt = 0; out_q.delete();
      n_switch = 0; n_overlap = 0; n_consec = 0; n_toggle = 0;
      first_switch_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
      prev_sw = 1'b0; prev_bank_sel = 1'b0;
   endtask

   // Samples one cycle 1 time unit after the inputs were set (mid-cycle).
   task automatic observe();
      #1;
      if (in_valid && in_ready) acc_cnt++;
      if (out_valid && out_ready) begin
         out_q.push_back(out_data);
         if (first_out_cyc < 0) first_out_cyc = cyc;
         last_out_cyc = cyc;
      end
      if (db_switch_banks) begin
         n_switch++;
         if (first_switch_cyc < 0) first_switch_cyc = cyc;
         if (db_wen || db_ren) n_overlap++;
         if (prev_sw) n_consec++;
      end
      prev_sw = db_switch_banks;
      if (bank_sel !== prev_bank_sel) n_toggle++;
      prev_bank_sel = bank_sel;
      cyc++;
   endtask

   task automatic tick();
      observe();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_log();
   endtask

   task automatic test_reset();
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      #2 rst_n = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (db_wen !== 1'b0) begin bad++; $display("FAIL reset_db_wen: got %b want 0", db_wen); end
      total++; if (db_ren !== 1'b0) begin bad++; $display("FAIL reset_db_ren: got %b want 0", db_ren); end
      total++; if (db_switch_banks !== 1'b0) begin bad++; $display("FAIL reset_switch: got %b want 0", db_switch_banks); end
      total++; if (bank_sel !== 1'b0) begin bad++; $display("FAIL reset_bank_sel: got %b want 0", bank_sel); end
      total++; if (db_wadr !== '0 || db_radr !== '0) begin bad++; $display("FAIL reset_addr: wadr=%0d radr=%0d want 0 0", db_wadr, db_radr); end
      @(negedge clk);
      rst_n = 1'b1;
      clear_log();
   endtask

   task automatic test_first_fill();
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < BS; k++) begin
         in_valid = 1'b1; in_data = DW'(k);
         observe();
         total++;
         if (db_wen !== 1'b1 || db_wadr !== AW'(k)) begin
            bad++; $display("FAIL fill_write%0d: wen=%b wadr=%0d want wen=1 wadr=%0d", k, db_wen, db_wadr, k);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      total++; if (first_switch_cyc != 4) begin bad++; $display("FAIL fill_switch_cyc: got %0d want 4", first_switch_cyc); end
      total++; if (n_switch != 1) begin bad++; $display("FAIL fill_switch_cnt: got %0d want 1", n_switch); end
      total++; if (first_out_cyc != 7) begin bad++; $display("FAIL fill_first_out: got %0d want 7", first_out_cyc); end
      total++; if (last_out_cyc != 10) begin bad++; $display("FAIL fill_last_out: got %0d want 10", last_out_cyc); end
      total++; if (out_q.size() != BS) begin bad++; $display("FAIL fill_out_cnt: got %0d want %0d", out_q.size(), BS); end
      for (int i = 0; i < out_q.size() && i < BS; i++) begin
         total++; if (out_q[i] !== DW'(i)) begin bad++; $display("FAIL fill_out%0d: got %0d want %0d", i, out_q[i], i); end
      end
   endtask

   task automatic test_continuous();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 200 && acc_cnt < 16; i++) begin
         in_valid = 1'b1; in_data = DW'(acc_cnt);
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 200 && out_q.size() < 16; i++) tick();
      for (int i = 0; i < 4; i++) tick();
      total++; if (out_q.size() != 16) begin bad++; $display("FAIL cont_out_cnt: got %0d want 16", out_q.size()); end
      for (int i = 0; i < out_q.size() && i < 16; i++) begin
         total++; if (out_q[i] !== DW'(i)) begin bad++; $display("FAIL cont_out%0d: got %0d want %0d", i, out_q[i], i); end
      end
      total++; if (n_switch != 4) begin bad++; $display("FAIL cont_switch_cnt: got %0d want 4", n_switch); end
      total++; if (n_toggle != 4) begin bad++; $display("FAIL cont_toggle_cnt: got %0d want 4", n_toggle); end
      total++; if (bank_sel !== 1'b0) begin bad++; $display("FAIL cont_bank_sel_end: got %b want 0", bank_sel); end
      total++; if (n_consec != 0) begin bad++; $display("FAIL cont_consec_switch: got %0d want 0", n_consec); end
   endtask

   task automatic test_back_pressure();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 40 && acc_cnt < 8; i++) begin
         in_valid = 1'b1; in_data = DW'(acc_cnt);
         tick();
      end
      in_valid = 1'b1; in_data = DW'(8);
      for (int i = 0; i < 6; i++) tick();
      observe();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      total++; if (acc_cnt != 8) begin bad++; $display("FAIL bp_accepted: got %0d want 8", acc_cnt); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
      total++; if (out_data !== DW'(0)) begin bad++; $display("FAIL bp_out_data: got %0d want 0", out_data); end
      total++; if (db_ren !== 1'b0) begin bad++; $display("FAIL bp_read_stall: got %b want 0", db_ren); end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 100 && out_q.size() < 8; i++) tick();
      for (int i = 0; i < 4; i++) tick();
      total++; if (out_q.size() != 8) begin bad++; $display("FAIL bp_out_cnt: got %0d want 8", out_q.size()); end
      for (int i = 0; i < out_q.size() && i < 8; i++) begin
         total++; if (out_q[i] !== DW'(i)) begin bad++; $display("FAIL bp_out%0d: got %0d want %0d", i, out_q[i], i); end
      end
   endtask

   task automatic test_random_gaps();
      do_reset();
      for (int i = 0; i < 3000 && acc_cnt < 64; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = DW'(300 + acc_cnt);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 400 && out_q.size() < 64; i++) tick();
      for (int i = 0; i < 4; i++) tick();
      total++; if (acc_cnt != 64) begin bad++; $display("FAIL rnd_accepted: got %0d want 64", acc_cnt); end
      total++; if (out_q.size() != 64) begin bad++; $display("FAIL rnd_out_cnt: got %0d want 64", out_q.size()); end
      for (int i = 0; i < out_q.size() && i < 64; i++) begin
         total++; if (out_q[i] !== DW'(300 + i)) begin bad++; $display("FAIL rnd_out%0d: got %0d want %0d", i, out_q[i], 300 + i); end
      end
      total++; if (n_switch != 16) begin bad++; $display("FAIL rnd_switch_cnt: got %0d want 16", n_switch); end
      total++; if (n_overlap != 0) begin bad++; $display("FAIL rnd_switch_overlap: got %0d want 0", n_overlap); end
      total++; if (n_consec != 0) begin bad++; $display("FAIL rnd_consec_switch: got %0d want 0", n_consec); end
   endtask

   task automatic test_reset_mid_block();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 40 && acc_cnt < 6; i++) begin
         in_valid = 1'b1; in_data = DW'(acc_cnt);
         tick();
      end
      in_valid = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
      total++; if (db_wen !== 1'b0 || db_ren !== 1'b0) begin bad++; $display("FAIL mid_enables: wen=%b ren=%b want 0 0", db_wen, db_ren); end
      total++; if (db_switch_banks !== 1'b0) begin bad++; $display("FAIL mid_switch: got %b want 0", db_switch_banks); end
      total++; if (bank_sel !== 1'b0) begin bad++; $display("FAIL mid_bank_sel: got %b want 0", bank_sel); end
      total++; if (db_wadr !== '0 || db_radr !== '0) begin bad++; $display("FAIL mid_addr: wadr=%0d radr=%0d want 0 0", db_wadr, db_radr); end
      @(negedge clk);
      rst_n = 1'b1;
      clear_log();
      out_ready = 1'b1;
      for (int i = 0; i < 40 && acc_cnt < 4; i++) begin
         in_valid = 1'b1; in_data = DW'(100 + acc_cnt);
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      total++; if (out_q.size() != 4) begin bad++; $display("FAIL mid_out_cnt: got %0d want 4", out_q.size()); end
      for (int i = 0; i < out_q.size() && i < 4; i++) begin
         total++; if (out_q[i] !== DW'(100 + i)) begin bad++; $display("FAIL mid_out%0d: got %0d want %0d", i, out_q[i], 100 + i); end
      end
      total++; if (n_switch != 1) begin bad++; $display("FAIL mid_switch_cnt: got %0d want 1", n_switch); end
   endtask

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      clear_log();
      test_reset();
      test_first_fill();
      test_continuous();
      test_back_pressure();
      test_random_gaps();
      test_reset_mid_block();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "time limit");
   end

endmodule
